// File: rtl/trace_nop_event_tx.sv
// Captures l.nop K events from one core's retirement trace together with the shadowed r3,
// buffers them, and streams each one as a 4-word packet (header, K, r3 high, r3 low).
module trace_nop_event_tx #(
    parameter int CORE_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_valid,
    input  logic [31:0] trace_insn,
    input  logic        trace_wben,
    input  logic [4:0]  trace_wbreg,
    input  logic [31:0] trace_wbdata,
    output logic [15:0] fifo_out_data,
    output logic        fifo_out_valid,
    input  logic        fifo_out_ready,
    output logic        terminated,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [11:0] CORE_ID_W = 12'(CORE_ID);
    localparam logic [AW:0] DEPTH_W   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_W     = (AW+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_CODE = 3'd2,
        ST_R3H  = 3'd3,
        ST_R3L  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [31:0]   r3_r;
    logic [47:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r;
    logic          exit_seen_r;
    logic          valid_r, valid_s;
    logic [15:0]   data_r, data_s;
    logic          terminated_r, overflow_r;
    logic [15:0]   drop_count_r;

    logic          event_s, full_s, handshake_s, pop_s, push_s, drop_s;
    logic [47:0]   head_s;

    assign event_s     = trace_valid && (trace_insn[31:16] == 16'h1500) &&
                         (trace_insn[15:0] != 16'h0000) && !exit_seen_r;
    assign full_s      = (count_r == DEPTH_W);
    assign handshake_s = valid_r && fifo_out_ready;
    assign pop_s       = handshake_s && (state_r == ST_R3L);
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push_s      = event_s && (!full_s || pop_s);
    assign drop_s      = event_s && full_s && !pop_s;
    assign head_s      = mem_r[rd_ptr_r];

    // Packet sequencer next state plus the next registered stream word.
    always_comb begin
        state_s = state_r;
        valid_s = 1'b0;
        data_s  = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) state_s = ST_HDR;
                else               state_s = ST_IDLE;
            end
            ST_HDR: begin
                if (handshake_s) state_s = ST_CODE;
                else             state_s = ST_HDR;
            end
            ST_CODE: begin
                if (handshake_s) state_s = ST_R3H;
                else             state_s = ST_CODE;
            end
            ST_R3H: begin
                if (handshake_s) state_s = ST_R3L;
                else             state_s = ST_R3H;
            end
            ST_R3L: begin
                if (handshake_s) state_s = (count_r > ONE_W) ? ST_HDR : ST_IDLE;
                else             state_s = ST_R3L;
            end
            default: state_s = ST_IDLE;
        endcase
        // The head only changes on entry to HDR, whose word does not depend on it.
        case (state_s)
            ST_HDR:  data_s = {4'hA, CORE_ID_W};
            ST_CODE: data_s = head_s[47:32];
            ST_R3H:  data_s = head_s[31:16];
            ST_R3L:  data_s = head_s[15:0];
            default: data_s = 16'h0000;
        endcase
        valid_s = (state_s != ST_IDLE);
    end

    // Sequencer state and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            data_r  <= 16'h0000;
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            data_r  <= data_s;
        end
    end

    // r3 shadow; the event captures the value held before its own cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_r <= 32'h0000_0000;
        end else if (trace_valid && trace_wben && (trace_wbreg == 5'd3)) begin
            r3_r <= trace_wbdata;
        end else begin
            r3_r <= r3_r;
        end
    end

    // Event storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {trace_insn[15:0], r3_r};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_W;
                2'b01:   count_r <= count_r - ONE_W;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky status: exit seen, termination, overflow and saturating drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_seen_r  <= 1'b0;
            terminated_r <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else begin
            if (push_s && (trace_insn[15:0] == 16'h0001)) exit_seen_r <= 1'b1;
            if (pop_s && (head_s[47:32] == 16'h0001))     terminated_r <= 1'b1;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) drop_count_r <= drop_count_r + 16'h0001;
            end
        end
    end

    assign fifo_out_data  = data_r;
    assign fifo_out_valid = valid_r;
    assign terminated     = terminated_r;
    assign overflow       = overflow_r;
    assign drop_count     = drop_count_r;

endmodule

// File: tb/tb_trace_nop_event_tx.sv
// Self-checking bench for trace_nop_event_tx: vector table, directed corner sequences and
// random traffic checked against a queue-based packet model.
module tb_trace_nop_event_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_valid = 1'b0;
    logic [31:0] trace_insn = 32'h0;
    logic        trace_wben = 1'b0;
    logic [4:0]  trace_wbreg = 5'd0;
    logic [31:0] trace_wbdata = 32'h0;
    logic [15:0] fifo_out_data;
    logic        fifo_out_valid;
    logic        fifo_out_ready = 1'b0;
    logic        terminated, overflow;
    logic [15:0] drop_count;

    trace_nop_event_tx #(.CORE_ID(5), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .trace_valid(trace_valid), .trace_insn(trace_insn), .trace_wben(trace_wben),
        .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
        .fifo_out_data(fifo_out_data), .fifo_out_valid(fifo_out_valid),
        .fifo_out_ready(fifo_out_ready), .terminated(terminated),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of pending events, beat position within the head packet.
    logic [47:0] mq[$];
    int          mbeat;
    bit          mactive;
    logic [31:0] r3m;
    bit          exit_m, term_m, ovf_m;
    int          drops_m;
    logic [15:0] got_q[$];

    typedef struct {
        bit          tv;
        logic [31:0] insn;
        bit          wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        bit          rdy;
        bit          exp_valid;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [47:0] e, input int b);
        case (b)
            0:       return 16'hA005;
            1:       return e[47:32];
            2:       return e[31:16];
            default: return e[15:0];
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        got_q.delete();
        mbeat = 0; mactive = 0; r3m = 32'h0;
        exit_m = 0; term_m = 0; ovf_m = 0; drops_m = 0;
    endtask

    task automatic check_model();
        check("valid", {31'h0, fifo_out_valid}, {31'h0, mactive});
        if (mactive) check("data", {16'h0, fifo_out_data}, {16'h0, model_word(mq[0], mbeat)});
        check("terminated", {31'h0, terminated}, {31'h0, term_m});
        check("overflow", {31'h0, overflow}, {31'h0, ovf_m});
        check("drop_count", {16'h0, drop_count}, drops_m);
    endtask

    task automatic apply(input bit tv, input logic [31:0] insn, input bit wben,
                         input logic [4:0] wbreg, input logic [31:0] wbdata, input bit rdy);
        int sz;
        bit popm;
        trace_valid = tv; trace_insn = insn; trace_wben = wben;
        trace_wbreg = wbreg; trace_wbdata = wbdata; fifo_out_ready = rdy;
        if (fifo_out_valid && rdy) got_q.push_back(fifo_out_data);
        sz = mq.size();
        popm = 0;
        if (mactive) begin
            if (rdy) begin
                if (mbeat == 3) begin
                    popm = 1;
                    if (mq[0][47:32] == 16'h0001) term_m = 1;
                    void'(mq.pop_front());
                    mbeat = 0;
                    mactive = (mq.size() > 0);
                end else begin
                    mbeat++;
                end
            end
        end else begin
            mactive = (sz > 0);
        end
        if (tv && insn[31:16] == 16'h1500 && insn[15:0] != 16'h0 && !exit_m) begin
            if (sz < DEPTH || popm) begin
                mq.push_back({insn[15:0], r3m});
                if (insn[15:0] == 16'h0001) exit_m = 1;
            end else begin
                ovf_m = 1;
                if (drops_m < 65535) drops_m++;
            end
        end
        if (tv && wben && wbreg == 5'd3) r3m = wbdata;
    endtask

    task automatic cycle(input bit tv, input logic [31:0] insn, input bit wben,
                         input logic [4:0] wbreg, input logic [31:0] wbdata, input bit rdy);
        @(negedge clk);
        check_model();
        apply(tv, insn, wben, wbreg, wbdata, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 5'd0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        trace_valid = 1'b0; trace_wben = 1'b0; fifo_out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0] = '{1, 32'hE060_0000, 1, 5'd3, 32'h0000_0041, 1, 0, 16'h0};
        vt[1] = '{1, 32'h1500_0004, 0, 5'd0, 32'h0,         1, 0, 16'h0};
        vt[2] = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 0, 16'h0};
        vt[3] = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 1, 16'hA005};
        vt[4] = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 1, 16'h0004};
        vt[5] = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 1, 16'h0000};
        vt[6] = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 1, 16'h0041};
        vt[7] = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 0, 16'h0};

        do_reset();
        @(negedge clk);
        check("reset_valid", {31'h0, fifo_out_valid}, 32'h0);
        check("reset_data", {16'h0, fifo_out_data}, 32'h0);
        check("reset_drops", {16'h0, drop_count}, 32'h0);
        check("reset_flags", {30'h0, terminated, overflow}, 32'h0);

        // Basic packet with exact N+2 latency, from the vector table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_model();
            check("tbl_valid", {31'h0, fifo_out_valid}, {31'h0, vt[i].exp_valid});
            if (vt[i].exp_valid) check("tbl_data", {16'h0, fifo_out_data}, {16'h0, vt[i].exp_data});
            apply(vt[i].tv, vt[i].insn, vt[i].wben, vt[i].wbreg, vt[i].wbdata, vt[i].rdy);
        end

        // Same packet with ready toggling every cycle.
        do_reset();
        cycle(1, 32'hE060_0000, 1, 5'd3, 32'h41, 1);
        cycle(1, 32'h1500_0004, 0, 5'd0, 32'h0, 0);
        for (int i = 0; i < 14; i++) idle(1, i[0]);
        check("toggle_beats", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("toggle_w0", {16'h0, got_q[0]}, 32'hA005);
            check("toggle_w1", {16'h0, got_q[1]}, 32'h0004);
            check("toggle_w2", {16'h0, got_q[2]}, 32'h0000);
            check("toggle_w3", {16'h0, got_q[3]}, 32'h0041);
        end

        // Overflow: six events with the sink stalled, then drain.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 32'h1500_0002, 0, 5'd0, 32'h0, 0);
        idle(3, 0);
        check("ovf_drops", {16'h0, drop_count}, 32'd2);
        check("ovf_flag", {31'h0, overflow}, 32'd1);
        idle(24, 1);
        check("ovf_drain_beats", got_q.size(), 16);

        // r3 written the cycle before the event is carried in the packet.
        do_reset();
        cycle(1, 32'hE060_0000, 1, 5'd3, 32'h1234_5678, 1);
        cycle(1, 32'h1500_0004, 1, 5'd3, 32'hFFFF_FFFF, 1);
        idle(8, 1);
        check("r3_beats", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("r3_hi", {16'h0, got_q[2]}, 32'h1234);
            check("r3_lo", {16'h0, got_q[3]}, 32'h5678);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [15:0] k;
            logic [31:0] insn;
            k = 16'($urandom_range(0, 6));
            if (k == 16'h1 && $urandom_range(0, 60) != 0) k = 16'h2;
            if ($urandom_range(0, 9) < 4) insn = {16'h1500, k};
            else                          insn = $urandom;
            cycle($urandom_range(0, 3) != 0, insn, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? 5'd3 : 5'($urandom_range(0, 31)),
                  $urandom, $urandom_range(0, 3) != 0);
        end

        // Exit packet terminates and blocks later events.
        do_reset();
        cycle(1, 32'hE060_0000, 1, 5'd3, 32'hDEAD_BEEF, 1);
        cycle(1, 32'h1500_0001, 0, 5'd0, 32'h0, 1);
        cycle(1, 32'h1500_0004, 0, 5'd0, 32'h0, 1);
        idle(12, 1);
        check("exit_beats", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("exit_code", {16'h0, got_q[1]}, 32'h0001);
            check("exit_hi", {16'h0, got_q[2]}, 32'hDEAD);
            check("exit_lo", {16'h0, got_q[3]}, 32'hBEEF);
        end
        check("exit_terminated", {31'h0, terminated}, 32'd1);
        check("exit_no_drop", {16'h0, drop_count}, 32'd0);

        // Reset asserted during the CODE beat.
        do_reset();
        cycle(1, 32'h1500_0004, 0, 5'd0, 32'h0, 1);
        idle(2, 1);
        @(negedge clk);
        check("rst_code_valid", {31'h0, fifo_out_valid}, 32'd1);
        check("rst_code_data", {16'h0, fifo_out_data}, 32'h0004);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'h0, fifo_out_valid}, 32'd0);
        model_reset();
        trace_valid = 1'b0; fifo_out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6, 1);
        check("rst_no_output", got_q.size(), 0);
        cycle(1, 32'h1500_0003, 0, 5'd0, 32'h0, 1);
        idle(8, 1);
        check("rst_new_packet", got_q.size(), 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
